// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use stall control for the 5-stage pipeline.
// Keeps a shadow copy of ID/EX, EX/MEM and MEM/WB register-use bits so
// the EX forwarding selects come straight from registered state.
//
// Ports:
//   clk, arst            rising-edge clock, async active-high reset
//   enable               pipeline advance (0 = hold everything)
//   flush                discard the instruction currently in ID
//   id_rs1/rs2/rd        register addresses of the ID instruction
//   id_reg_write         ID instruction writes the register file
//   id_mem_read          ID instruction is a load
//   select_a/select_b    00 = regfile, 01 = MEM/WB, 10 = EX/MEM
//   stall                load-use hazard, hold PC and IF/ID
//   stall_count          saturating stall-cycle counter
//
// Optional feature: define FWD_STALL_CNT_EN to build the stall counter;
// without it stall_count is tied to zero.
module fwd_hazard_ctrl #(
    parameter int REG_ADDR_W  = 5,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic                   enable,
    input  logic                   flush,
    input  logic [REG_ADDR_W-1:0]  id_rs1,
    input  logic [REG_ADDR_W-1:0]  id_rs2,
    input  logic [REG_ADDR_W-1:0]  id_rd,
    input  logic                   id_reg_write,
    input  logic                   id_mem_read,
    output logic [1:0]             select_a,
    output logic [1:0]             select_b,
    output logic                   stall,
    output logic [STALL_CNT_W-1:0] stall_count
);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } id_ex_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
    } wr_t;

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_WB  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    id_ex_t id_ex_q, id_ex_d;
    wr_t    ex_mem_q, ex_mem_d;
    wr_t    mem_wb_q, mem_wb_d;

    logic load_use;

    // A producer only counts if it writes a non-x0 register matching rs.
    function automatic logic hit(
        input wr_t                   p,
        input logic [REG_ADDR_W-1:0] rs
    );
        return p.reg_write && (p.rd != '0) && (p.rd == rs);
    endfunction

    // EX/MEM holds the younger producer, so it wins over MEM/WB.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] rs,
        input wr_t                   mem,
        input wr_t                   wb
    );
        logic [1:0] s;
        s = SEL_RF;
        if (hit(mem, rs)) begin
            s = SEL_MEM;
        end else if (hit(wb, rs)) begin
            s = SEL_WB;
        end
        return s;
    endfunction

    always_comb begin
        select_a = fwd_sel(id_ex_q.rs1, ex_mem_q, mem_wb_q);
        select_b = fwd_sel(id_ex_q.rs2, ex_mem_q, mem_wb_q);
    end

    // A load in EX whose result the ID instruction needs; a flush
    // discards that ID instruction, so the hazard disappears.
    always_comb begin
        load_use = id_ex_q.mem_read
                 & id_ex_q.reg_write
                 & (id_ex_q.rd != '0)
                 & ((id_ex_q.rd == id_rs1) | (id_ex_q.rd == id_rs2));
        stall    = load_use & ~flush;
    end

    always_comb begin
        id_ex_d  = id_ex_q;
        ex_mem_d = ex_mem_q;
        mem_wb_d = mem_wb_q;
        if (enable) begin
            mem_wb_d           = ex_mem_q;
            ex_mem_d.rd        = id_ex_q.rd;
            ex_mem_d.reg_write = id_ex_q.reg_write;
            if (flush || stall) begin
                id_ex_d = '0;
            end else begin
                id_ex_d.rs1       = id_rs1;
                id_ex_d.rs2       = id_rs2;
                id_ex_d.rd        = id_rd;
                id_ex_d.reg_write = id_reg_write;
                id_ex_d.mem_read  = id_mem_read;
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            id_ex_q  <= '0;
            ex_mem_q <= '0;
            mem_wb_q <= '0;
        end else begin
            id_ex_q  <= id_ex_d;
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
        end
    end

`ifdef FWD_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Saturates at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (enable && stall && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
`else
    assign stall_count = '0;
`endif

endmodule
